// File: rtl/rx_pkt_ctrl_if.sv
// rtl/rx_pkt_ctrl_if.sv - PD/BD-facing inputs and packet outputs of the receive packet sequencer
interface rx_pkt_ctrl_if #(
  parameter int LEN_WIDTH = 8
);
  logic                 i_en;
  logic                 i_PD_flag;
  logic                 i_BD_flag;
  logic                 i_BD_sgn;
  logic                 i_BPSK;
  logic                 o_disassert_BD;
  logic                 o_pkt_busy;
  logic [LEN_WIDTH-1:0] o_hdr_len;
  logic [7:0]           o_byte_out;
  logic                 o_byte_vld;
  logic                 o_pkt_start;
  logic                 o_pkt_done;
  logic                 o_pkt_err;
  logic [1:0]           o_err_code;

  modport master (
    output i_en, i_PD_flag, i_BD_flag, i_BD_sgn, i_BPSK,
    input  o_disassert_BD, o_pkt_busy, o_hdr_len, o_byte_out, o_byte_vld,
    input  o_pkt_start, o_pkt_done, o_pkt_err, o_err_code
  );

  modport slave (
    input  i_en, i_PD_flag, i_BD_flag, i_BD_sgn, i_BPSK,
    output o_disassert_BD, o_pkt_busy, o_hdr_len, o_byte_out, o_byte_vld,
    output o_pkt_start, o_pkt_done, o_pkt_err, o_err_code
  );
endinterface

// File: rtl/rx_pkt_ctrl.sv
// rtl/rx_pkt_ctrl.sv - receive packet sequencer (header/payload deserialiser); RX_PKT_TIMEOUT_EN enables the WAIT_BD timeout
module rx_pkt_ctrl #(
  parameter int LEN_WIDTH   = 8,
  parameter int MAX_LEN     = 64
`ifdef RX_PKT_TIMEOUT_EN
  , parameter int BD_TIMEOUT  = 1024
  , parameter int TIMER_WIDTH = 11
`endif
) (
  input  logic           clk,
  input  logic           rst,
  rx_pkt_ctrl_if.slave   bus
);

  // Shift register wide enough for either the header or a payload byte.
  localparam int SW  = (LEN_WIDTH > 8) ? LEN_WIDTH : 8;
  // Bit counter must reach LEN_WIDTH-1 in the header and 7 in the payload.
  localparam int BCW = ($clog2(LEN_WIDTH + 1) > 3) ? $clog2(LEN_WIDTH + 1) : 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_BD,
    S_HEADER,
    S_PAYLOAD,
    S_DONE,
    S_ABORT,
    S_REARM
  } state_t;

  state_t               r_state;
  logic [SW-1:0]        r_shift;
  logic [BCW-1:0]       r_bit_cnt;
  logic [LEN_WIDTH-1:0] r_byte_cnt;
  logic [LEN_WIDTH-1:0] r_hdr_len;
  logic [7:0]           r_byte_out;
  logic                 r_disassert;
  logic                 r_busy;
  logic                 r_byte_vld;
  logic                 r_pkt_start;
  logic                 r_pkt_done;
  logic                 r_pkt_err;
  logic [1:0]           r_err_code;
`ifdef RX_PKT_TIMEOUT_EN
  logic [TIMER_WIDTH-1:0] r_timer;
`endif

  logic                 w_d;
  logic [SW-1:0]        w_shift_next;
  logic [LEN_WIDTH-1:0] w_len;
  logic [7:0]           w_byte;
  logic                 w_last_bit_of_byte;
  logic                 w_last_byte;

  // Polarity-corrected data bit and the words completed by this cycle's bit.
  assign w_d                = bus.i_BPSK ^ bus.i_BD_sgn;
  assign w_shift_next       = {r_shift[SW-2:0], w_d};
  assign w_len              = {r_shift[LEN_WIDTH-2:0], w_d};
  assign w_byte             = {r_shift[6:0], w_d};
  assign w_last_bit_of_byte = (r_bit_cnt == BCW'(7));
  assign w_last_byte        = (r_byte_cnt == r_hdr_len - LEN_WIDTH'(1));

  // Packet sequencer: state, counters and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_byte_cnt  <= '0;
      r_hdr_len   <= '0;
      r_byte_out  <= '0;
      r_disassert <= 1'b0;
      r_busy      <= 1'b0;
      r_byte_vld  <= 1'b0;
      r_pkt_start <= 1'b0;
      r_pkt_done  <= 1'b0;
      r_pkt_err   <= 1'b0;
      r_err_code  <= 2'b00;
`ifdef RX_PKT_TIMEOUT_EN
      r_timer     <= '0;
`endif
    end else begin
      r_disassert <= 1'b0;
      r_byte_vld  <= 1'b0;
      r_pkt_start <= 1'b0;
      r_pkt_done  <= 1'b0;
      r_pkt_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.i_en && bus.i_PD_flag && !bus.i_BD_flag) begin
            r_state <= S_WAIT_BD;
            r_busy  <= 1'b1;
`ifdef RX_PKT_TIMEOUT_EN
            r_timer <= '0;
`endif
          end
        end
        S_WAIT_BD: begin
          if (!bus.i_PD_flag) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (bus.i_BD_flag) begin
            // The lock cycle already carries the header MSB.
            r_shift   <= w_shift_next;
            r_bit_cnt <= BCW'(1);
            r_state   <= S_HEADER;
          end
`ifdef RX_PKT_TIMEOUT_EN
          else if (r_timer == TIMER_WIDTH'(BD_TIMEOUT - 1)) begin
            r_state     <= S_ABORT;
            r_pkt_err   <= 1'b1;
            r_disassert <= 1'b1;
            r_err_code  <= 2'b01;
          end else begin
            r_timer <= r_timer + TIMER_WIDTH'(1);
          end
`endif
        end
        S_HEADER: begin
          if (!bus.i_PD_flag) begin
            r_state     <= S_ABORT;
            r_pkt_err   <= 1'b1;
            r_disassert <= 1'b1;
            r_err_code  <= 2'b10;
          end else if (r_bit_cnt == BCW'(LEN_WIDTH - 1)) begin
            r_hdr_len  <= w_len;
            r_bit_cnt  <= '0;
            r_byte_cnt <= '0;
            if (w_len > LEN_WIDTH'(MAX_LEN)) begin
              r_state     <= S_ABORT;
              r_pkt_err   <= 1'b1;
              r_disassert <= 1'b1;
              r_err_code  <= 2'b11;
            end else begin
              r_pkt_start <= 1'b1;
              // Zero length enters DONE without pulses; DONE emits them next cycle.
              r_state     <= (w_len == '0) ? S_DONE : S_PAYLOAD;
            end
          end else begin
            r_shift   <= w_shift_next;
            r_bit_cnt <= r_bit_cnt + BCW'(1);
          end
        end
        S_PAYLOAD: begin
          if (w_last_bit_of_byte && w_last_byte) begin
            // Completing the packet takes priority over a simultaneous PD loss.
            r_byte_out  <= w_byte;
            r_byte_vld  <= 1'b1;
            r_pkt_done  <= 1'b1;
            r_disassert <= 1'b1;
            r_state     <= S_DONE;
          end else if (!bus.i_PD_flag) begin
            r_state     <= S_ABORT;
            r_pkt_err   <= 1'b1;
            r_disassert <= 1'b1;
            r_err_code  <= 2'b10;
          end else begin
            r_shift   <= w_shift_next;
            r_bit_cnt <= r_bit_cnt + BCW'(1);
            if (w_last_bit_of_byte) begin
              r_byte_out <= w_byte;
              r_byte_vld <= 1'b1;
              r_bit_cnt  <= '0;
              r_byte_cnt <= r_byte_cnt + LEN_WIDTH'(1);
            end
          end
        end
        S_DONE: begin
          if (!r_pkt_done) begin
            r_pkt_done  <= 1'b1;
            r_disassert <= 1'b1;
          end else begin
            r_state <= S_REARM;
          end
        end
        S_ABORT: begin
          r_state <= S_REARM;
        end
        S_REARM: begin
          // Hold off until the BD has actually dropped its stale lock.
          if (!bus.i_BD_flag) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_disassert_BD = r_disassert;
  assign bus.o_pkt_busy     = r_busy;
  assign bus.o_hdr_len      = r_hdr_len;
  assign bus.o_byte_out     = r_byte_out;
  assign bus.o_byte_vld     = r_byte_vld;
  assign bus.o_pkt_start    = r_pkt_start;
  assign bus.o_pkt_done     = r_pkt_done;
  assign bus.o_pkt_err      = r_pkt_err;
  assign bus.o_err_code     = r_err_code;

endmodule

// File: tb/tb_rx_pkt_ctrl.sv
// tb/tb_rx_pkt_ctrl.sv - directed table-driven bench for rx_pkt_ctrl
module tb_rx_pkt_ctrl;

  localparam logic [5:0] F_DIS   = 6'b100000;
  localparam logic [5:0] F_BUSY  = 6'b010000;
  localparam logic [5:0] F_VLD   = 6'b001000;
  localparam logic [5:0] F_START = 6'b000100;
  localparam logic [5:0] F_DONE  = 6'b000010;
  localparam logic [5:0] F_NONE  = 6'b000000;

  typedef struct {
    logic       rst, en, pd, bd, sgn, bpsk;
    logic [5:0] e_flags;  // {disassert, busy, vld, start, done, err}
    logic [1:0] e_code;
    logic       ch;
    logic [7:0] e_hdr;
    logic       cb;
    logic [7:0] e_byte;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rx_pkt_ctrl_if #(.LEN_WIDTH(8)) u_if ();

  rx_pkt_ctrl #(.LEN_WIDTH(8), .MAX_LEN(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  int   c_start, c_vld, c_done, c_err, c_dis;
  vec_t tbl[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic clear_counts();
    c_start = 0; c_vld = 0; c_done = 0; c_err = 0; c_dis = 0;
  endtask

  task automatic cyc(input logic en, input logic pd, input logic bd, input logic sgn, input logic bpsk);
    u_if.i_en = en; u_if.i_PD_flag = pd; u_if.i_BD_flag = bd;
    u_if.i_BD_sgn = sgn; u_if.i_BPSK = bpsk;
    @(posedge clk);
    #1;
    c_start += int'(u_if.o_pkt_start);
    c_vld   += int'(u_if.o_byte_vld);
    c_done  += int'(u_if.o_pkt_done);
    c_err   += int'(u_if.o_pkt_err);
    c_dis   += int'(u_if.o_disassert_BD);
  endtask

  task automatic send_bits(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0, v[7-i]);
  endtask

  task automatic push(input logic r, input logic e, input logic p, input logic b, input logic s,
                      input logic k, input logic [5:0] f, input logic ch, input logic [7:0] eh,
                      input logic cb, input logic [7:0] eb);
    vec_t v;
    v.rst = r; v.en = e; v.pd = p; v.bd = b; v.sgn = s; v.bpsk = k;
    v.e_flags = f; v.e_code = 2'b00;
    v.ch = ch; v.e_hdr = eh; v.cb = cb; v.e_byte = eb;
    tbl.push_back(v);
  endtask

  // alt: en dropped after start and PD lost on the final payload bit.
  task automatic build_pkt(input logic sgn, input logic alt);
    logic [7:0] hdr;
    logic [7:0] pl [2];
    logic       last;
    hdr = 8'h02; pl[0] = 8'hA5; pl[1] = 8'h3C;
    push(1'b0, 1'b1, 1'b1, 1'b0, sgn, 1'b0, F_BUSY, 1'b0, 8'h00, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++)
      push(1'b0, !alt, 1'b1, 1'b1, sgn, hdr[7-i] ^ sgn,
           (i == 7) ? (F_BUSY | F_START) : F_BUSY, i == 7, 8'h02, 1'b0, 8'h00);
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 8; i++) begin
        last = (b == 1) && (i == 7);
        push(1'b0, !alt, !(alt && last), 1'b1, sgn, pl[b][7-i] ^ sgn,
             F_BUSY | ((i == 7) ? F_VLD : F_NONE) | (last ? (F_DONE | F_DIS) : F_NONE),
             1'b0, 8'h00, i == 7, pl[b]);
      end
    for (int k = 0; k < 3; k++)
      push(1'b0, 1'b1, !alt, 1'b1, sgn, 1'b0, F_BUSY, 1'b0, 8'h00, 1'b0, 8'h00);
    push(1'b0, 1'b1, 1'b0, 1'b0, sgn, 1'b0, F_NONE, 1'b1, 8'h02, 1'b1, 8'h3C);
  endtask

  initial begin
    clear_counts();
    u_if.i_en = 1'b0; u_if.i_PD_flag = 1'b0; u_if.i_BD_flag = 1'b0;
    u_if.i_BD_sgn = 1'b0; u_if.i_BPSK = 1'b0;

    push(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, F_NONE, 1'b1, 8'h00, 1'b1, 8'h00);
    build_pkt(1'b0, 1'b0);
    build_pkt(1'b1, 1'b1);

    foreach (tbl[j]) begin
      rst = tbl[j].rst;
      cyc(tbl[j].en, tbl[j].pd, tbl[j].bd, tbl[j].sgn, tbl[j].bpsk);
      check($sformatf("vec%0d flags", j),
            {u_if.o_disassert_BD, u_if.o_pkt_busy, u_if.o_byte_vld, u_if.o_pkt_start,
             u_if.o_pkt_done, u_if.o_pkt_err, u_if.o_err_code},
            {tbl[j].e_flags, tbl[j].e_code});
      if (tbl[j].ch) check($sformatf("vec%0d hdr_len", j), u_if.o_hdr_len, tbl[j].e_hdr);
      if (tbl[j].cb) check($sformatf("vec%0d byte_out", j), u_if.o_byte_out, tbl[j].e_byte);
    end
    rst = 1'b0;

    // Oversized header: abort with code 11, no start, no bytes.
    clear_counts();
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    send_bits(8'h50, 8);
    check("ovr err", u_if.o_pkt_err, 1);
    check("ovr code", u_if.o_err_code, 2'b11);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("ovr counts", {c_start[7:0], c_vld[7:0], c_dis[7:0], c_err[7:0]}, 32'h00_00_01_01);
    check("ovr idle", u_if.o_pkt_busy, 0);

    // PD lost three bits into the second byte of a 4-byte packet.
    clear_counts();
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    send_bits(8'h04, 8);
    send_bits(8'h11, 8);
    send_bits(8'h00, 3);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("pdl err", u_if.o_pkt_err, 1);
    check("pdl code", u_if.o_err_code, 2'b10);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("pdl counts", {c_start[7:0], c_vld[7:0], c_done[7:0], c_dis[7:0]}, 32'h01_01_00_01);
    check("pdl byte", u_if.o_byte_out, 8'h11);

    // Zero-length header: pkt_start then pkt_done on the next cycle.
    clear_counts();
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    send_bits(8'h00, 8);
    check("zl start", {u_if.o_pkt_start, u_if.o_pkt_done, u_if.o_hdr_len}, {2'b10, 8'h00});
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("zl done", {u_if.o_pkt_start, u_if.o_pkt_done, u_if.o_disassert_BD}, 3'b011);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("zl rearm", {u_if.o_pkt_done, u_if.o_pkt_busy}, 2'b01);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("zl idle", {u_if.o_pkt_busy, u_if.o_err_code}, 3'b010);
    check("zl counts", {c_start[7:0], c_done[7:0], c_dis[7:0], c_vld[7:0]}, 32'h01_01_01_00);

    // PD loss and BD lock in the same WAIT_BD cycle: silent return to IDLE.
    clear_counts();
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("wbd busy", u_if.o_pkt_busy, 1);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("wbd race", {u_if.o_pkt_busy, c_err[7:0], c_dis[7:0]}, 17'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // BD never locks.
    clear_counts();
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef RX_PKT_TIMEOUT_EN
    begin
      int n;
      n = 0;
      while (!u_if.o_pkt_err && n < 2000) begin
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        n++;
      end
      check("tmo cycle", n, 1024);
      check("tmo code", u_if.o_err_code, 2'b01);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
`else
    repeat (5000) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("notmo err", c_err, 0);
    check("notmo busy", u_if.o_pkt_busy, 1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("notmo exit", {u_if.o_pkt_busy, c_err[7:0], c_dis[7:0]}, 17'h0);
`endif

    // Reset mid-payload discards the packet without a disassert pulse.
    clear_counts();
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    send_bits(8'h02, 8);
    send_bits(8'hF0, 4);
    rst = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    check("rst outs", {u_if.o_pkt_busy, u_if.o_hdr_len, u_if.o_byte_out, u_if.o_err_code}, 19'h0);
    check("rst dis", c_dis, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_pkt_ctrl.md
Name: rx_pkt_ctrl

Overview:
Receive packet sequencer that sits downstream of the preamble detector (PD) and the boundary detector (BD), and runs at one BPSK symbol per clk.
- Waits for the BD lock and resolves the symbol polarity using BD_sgn.
- Parses a fixed-width length header, then deserialises the payload into bytes.
- Ends every packet, good or aborted, by pulsing disassert_BD so the BD re-arms for the next packet.

Parameters:
LEN_WIDTH, 8, width of header length field (payload length in bytes)
MAX_LEN, 64, largest accepted payload length in bytes; larger lengths abort the packet
BD_TIMEOUT, 1024, maximum cycles allowed in WAIT_BD before aborting
TIMER_WIDTH, 11, width of the timeout counter; must satisfy 2^TIMER_WIDTH > BD_TIMEOUT

Ports:
clk  in  1  clock, one symbol per cycle
rst  in  1  synchronous, active-high reset
en  in  1  permits new packet starts
PD_flag  in  1  preamble detected (level)
BD_flag  in  1  boundary locked (level)
BD_sgn  in  1  polarity captured by the BD
BPSK  in  1  hard symbol decision
disassert_BD  out  1  one-cycle pulse that clears the BD
pkt_busy  out  1  high in every state other than IDLE
hdr_len  out  LEN_WIDTH  decoded payload length; held until the next header
byte_out  out  8  deserialised payload byte
byte_vld  out  1  one-cycle strobe qualifying byte_out
pkt_start  out  1  one-cycle pulse when the header completes
pkt_done  out  1  one-cycle pulse on good packet end
pkt_err  out  1  one-cycle pulse on abort
err_code  out  2  01 timeout, 10 PD lost, 11 length > MAX_LEN; held until the next error

Behaviour:
- Reset: every output is 0; state IDLE; all counters 0. Reset mid-packet discards the packet without a disassert_BD pulse.
- Data bit: d = BPSK ^ BD_sgn.
- All outputs are registered.

States:
- IDLE: if en & PD_flag & ~BD_flag, go to WAIT_BD and clear the timer.
- WAIT_BD:
  - If ~PD_flag, return to IDLE silently (no error).
  - Else if BD_flag, d this cycle is header bit 0 (MSB first); go to HEADER with bit count 1.
  - Else the timer increments; when timer == BD_TIMEOUT-1, go to ABORT with err 01.
- HEADER:
  - Shift in d each cycle until LEN_WIDTH bits are received.
  - The cycle after the last bit: hdr_len updates and pkt_start pulses.
  - If len > MAX_LEN: ABORT with err 11, and pkt_start is suppressed.
  - If len == 0: go straight to DONE (pkt_start and pkt_done pulse in consecutive cycles).
  - Otherwise go to PAYLOAD.
- PAYLOAD:
  - Bits are MSB first within each byte.
  - byte_vld pulses the cycle after each 8th bit.
  - A byte counter tracks progress; after len bytes, go to DONE.
- DONE: disassert_BD=1 and pkt_done=1 for exactly one cycle, coincident with the last byte_vld; then go to REARM.
- ABORT: disassert_BD=1, pkt_err=1 and err_code set for exactly one cycle; then go to REARM.
- REARM: wait until BD_flag==0, then go to IDLE. This prevents a stale BD_flag from retriggering.

Boundary rules:
- PD_flag falling in HEADER or PAYLOAD goes to ABORT with err 10; any partial byte is dropped with no byte_vld.
- en going low does not abort a packet in progress; it only blocks the IDLE→WAIT_BD transition.
- In WAIT_BD, if PD loss and BD_flag occur in the same cycle, PD loss wins.
- If the packet ends and PD drops in the same cycle, DONE wins.
- Latency from the last payload symbol to pkt_done is 1 cycle.

Optional Feature:
RX_PKT_TIMEOUT_EN:
- Defined: the WAIT_BD timeout is active as described above.
- Undefined: there is no timer, WAIT_BD waits indefinitely, and err_code 01 is never produced; the TIMER_WIDTH logic is removed.

Test Plan:
- Good packet with BD_sgn=0, header 0x02, payload 0xA5,0x3C → pkt_start once, byte_vld twice with 0xA5 then 0x3C, pkt_done plus one disassert_BD pulse, err_code=00.
- Same stream fully inverted with BD_sgn=1 → identical bytes 0xA5,0x3C.
- Header 0x50 (80 > 64) → pkt_err, err_code=11, no pkt_start, no byte_vld, one disassert_BD pulse.
- PD_flag dropped 3 bits into the second byte of a 4-byte packet → exactly 1 byte_vld, pkt_err with err_code=10.
- RX_PKT_TIMEOUT_EN defined, PD_flag held high with BD_flag never asserting → pkt_err with err_code=01 on cycle 1024 after entering WAIT_BD; without the macro, no error after 5000 cycles.
- BD_flag held high for 3 cycles after DONE → stays in REARM, no new packet starts; header 0x00 case → pkt_start then pkt_done on the next cycle.
